// File: rtl/onchip_mem_stream_master_pkg.sv
// Shared constants and FSM state encoding for the on-chip memory stream master.
package onchip_mem_stream_master_pkg;

    localparam int DEF_ADDR_W     = 15;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MEM_DEPTH  = 25000;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/onchip_mem_stream_master_if.sv
// Command, stream and Avalon-MM signals of the stream master, bundled.
// master: the stream master's view; slave: the environment's view.
interface onchip_mem_stream_master_if
    import onchip_mem_stream_master_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    // command / status
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_write;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [ADDR_W-1:0]   cmd_len;
    logic                done;
    logic                err;
    // write-mode input stream
    logic                sink_valid;
    logic                sink_ready;
    logic [DATA_W-1:0]   sink_data;
    // read-mode output stream
    logic                src_valid;
    logic                src_ready;
    logic [DATA_W-1:0]   src_data;
    // Avalon-MM master
    logic [ADDR_W-1:0]   mem_address;
    logic [DATA_W/8-1:0] mem_byteenable;
    logic                mem_chipselect;
    logic                mem_write;
    logic [DATA_W-1:0]   mem_writedata;
    logic                mem_clken;
    logic                mem_reset_req;
    logic [DATA_W-1:0]   mem_readdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        output cmd_ready, done, err,
        input  sink_valid, sink_data,
        output sink_ready,
        input  src_ready,
        output src_valid, src_data,
        output mem_address, mem_byteenable, mem_chipselect, mem_write,
        output mem_writedata, mem_clken, mem_reset_req,
        input  mem_readdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  cmd_ready, done, err,
        output sink_valid, sink_data,
        input  sink_ready,
        output src_ready,
        input  src_valid, src_data,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write,
        input  mem_writedata, mem_clken, mem_reset_req,
        output mem_readdata
    );

endinterface

// File: rtl/onchip_mem_stream_master_sync_fifo.sv
// Synchronous FIFO used as the read-return buffer. DEPTH must be a power of two.
module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is allowed only when a pop frees a slot in the same cycle.
    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
    end

    // Storage array; contents are only observable through the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/onchip_mem_stream_master.sv
// Moves a block of words between a stream and an on-chip memory (read latency 1).
// The interface instance must be built with the same ADDR_W/DATA_W as this module.
module onchip_mem_stream_master
    import onchip_mem_stream_master_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input logic                          clk,
    input logic                          reset,
    onchip_mem_stream_master_if.master   bus
);

    localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [31:0]       DEPTH_U   = 32'(MEM_DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] left_q, left_d;      // reads still to issue / beats still to accept
    logic              err_q, err_d;
    logic              inflight_q, inflight_d;
    logic              wr_pend_q, wr_pend_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              cmd_fire, issue, accept, pop;
    logic [ADDR_W-1:0] addr_inc;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_head;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (inflight_q),
        .push_data_i (bus.mem_readdata),
        .pop_i       (pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Handshake qualifiers; a read is issued only when its return word has a guaranteed slot.
    always_comb begin
        addr_inc = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        cmd_fire = bus.cmd_valid && bus.cmd_ready;
        issue    = (state_q == ST_READ) && !fifo_full &&
                   ((32'(fifo_count) + 32'(inflight_q)) < 32'(FIFO_DEPTH));
        accept   = (state_q == ST_WRITE) && (left_q != '0) && bus.sink_valid;
        pop      = !fifo_empty && bus.src_ready;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            left_q     <= '0;
            err_q      <= 1'b0;
            inflight_q <= 1'b0;
            wr_pend_q  <= 1'b0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            left_q     <= left_d;
            err_q      <= err_d;
            inflight_q <= inflight_d;
            wr_pend_q  <= wr_pend_d;
            wdata_q    <= wdata_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        left_d     = left_q;
        err_d      = err_q;
        inflight_d = issue;
        wr_pend_d  = accept;
        wdata_d    = accept ? bus.sink_data : wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    addr_d = bus.cmd_addr;
                    left_d = bus.cmd_len;
                    err_d  = 1'b0;
                    if (32'(bus.cmd_addr) >= DEPTH_U) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (bus.cmd_len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = bus.cmd_write ? ST_WRITE : ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (issue) begin
                    addr_d = addr_inc;
                    left_d = left_q - 1'b1;
                    if (left_q == ADDR_W'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !inflight_q) state_d = ST_DONE;
            end
            ST_WRITE: begin
                if (accept)    left_d = left_q - 1'b1;
                if (wr_pend_q) addr_d = addr_inc;
                // Accept and strobe overlap; the strobe with nothing left to accept is the last.
                if (wr_pend_q && (left_q == '0)) state_d = ST_DONE;
            end
            ST_DONE: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        bus.cmd_ready      = (state_q == ST_IDLE) && !reset;
        bus.done           = (state_q == ST_DONE);
        bus.err            = (state_q == ST_DONE) && err_q;
        bus.sink_ready     = (state_q == ST_WRITE) && (left_q != '0);
        bus.src_valid      = !fifo_empty;
        bus.src_data       = fifo_empty ? '0 : fifo_head;
        bus.mem_chipselect = issue || ((state_q == ST_WRITE) && wr_pend_q);
        bus.mem_write      = (state_q == ST_WRITE) && wr_pend_q;
        bus.mem_address    = addr_q;
        bus.mem_writedata  = wdata_q;
        bus.mem_byteenable = '1;
        bus.mem_clken      = 1'b1;
        bus.mem_reset_req  = reset;
    end

endmodule
